hh_gate_integrator: RTL and testbench

//  Forward-Euler integrator for the Hodgkin-Huxley gating variables n, m, h.

---
 rtl/hh_gate_if.sv | 31 +++
 rtl/hh_gate_integrator.sv | 191 +++++++++++++++++++
 tb/tb_hh_gate_integrator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/hh_gate_if.sv
// Control, rate and gate-output bundle between the rate stage, the gate integrator
// and the membrane-current stage.
interface hh_gate_if;
  logic        start;
  logic        clear;
  logic [15:0] alpha_n;
  logic [15:0] alpha_m;
  logic [15:0] alpha_h;
  logic [15:0] beta_n;
  logic [15:0] beta_m;
  logic [15:0] beta_h;
  logic [15:0] n;
  logic [15:0] m;
  logic [15:0] h;
  logic        busy;
  logic        valid;

  // Controller / rate-producer side
  modport master (
    output start, clear,
    output alpha_n, alpha_m, alpha_h, beta_n, beta_m, beta_h,
    input  n, m, h, busy, valid
  );

  // Integrator side
  modport slave (
    input  start, clear,
    input  alpha_n, alpha_m, alpha_h, beta_n, beta_m, beta_h,
    output n, m, h, busy, valid
  );
endinterface

// File: rtl/hh_gate_integrator.sv
// Forward-Euler integrator for the Hodgkin-Huxley gates n, m, h (unsigned Q9.7),
// sharing one 16x16 multiplier across the three gates under a small FSM.
module hh_gate_integrator #(
  parameter int unsigned FRAC     = 7,
  parameter int unsigned DT_SHIFT = 4,
  parameter logic [15:0] N0       = 16'd41,
  parameter logic [15:0] M0       = 16'd7,
  parameter logic [15:0] H0       = 16'd76
) (
  input  logic      clk,
  input  logic      rst_n,
  hh_gate_if.slave  gi
);

  localparam int unsigned GW  = 16;
  localparam int unsigned PW  = 17;
  localparam int unsigned DW  = 18;
  localparam int unsigned SW  = 19;
  localparam logic [GW-1:0] ONE = GW'(32'd1 << FRAC);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL_A = 2'd1,
    MUL_B = 2'd2,
    UPD   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      g_q, g_d;
  logic [GW-1:0]   alpha_q [0:2];
  logic [GW-1:0]   alpha_d [0:2];
  logic [GW-1:0]   beta_q  [0:2];
  logic [GW-1:0]   beta_d  [0:2];
  logic [GW-1:0]   x_q     [0:2];
  logic [GW-1:0]   x_d     [0:2];
  logic [PW-1:0]   p1_q, p1_d;
  logic [PW-1:0]   p2_q, p2_d;
  logic            busy_q, busy_d;
  logic            valid_q, valid_d;

  logic [GW-1:0]   x_sel, a_sel, b_sel;
  logic [GW-1:0]   mul_l, mul_r;
  logic [31:0]     prod;
  logic [PW-1:0]   prod_frac;
  logic signed [DW-1:0] diff, diff_sh;
  logic signed [SW-1:0] sum_s;
  logic [GW-1:0]   x_new;

  // Operand selection for the gate currently being integrated
  always_comb begin
    x_sel = x_q[0];
    a_sel = alpha_q[0];
    b_sel = beta_q[0];
    case (g_q)
      2'd1: begin
        x_sel = x_q[1];
        a_sel = alpha_q[1];
        b_sel = beta_q[1];
      end
      2'd2: begin
        x_sel = x_q[2];
        a_sel = alpha_q[2];
        b_sel = beta_q[2];
      end
      default: ;
    endcase
  end

  // Shared multiplier: alpha*(1-x) in MUL_A, beta*x otherwise
  always_comb begin
    mul_l     = (state_q == MUL_A) ? a_sel : b_sel;
    mul_r     = (state_q == MUL_A) ? (ONE - x_sel) : x_sel;
    prod      = 32'(mul_l) * 32'(mul_r);
    prod_frac = PW'(prod >> FRAC);
  end

  // Euler update with floor rounding and saturation to [0, ONE]
  always_comb begin
    diff    = $signed({1'b0, p1_q}) - $signed({1'b0, p2_q});
    diff_sh = diff >>> DT_SHIFT;
    sum_s   = $signed({3'b000, x_sel}) + $signed({diff_sh[DW-1], diff_sh});
    if (sum_s[SW-1]) begin
      x_new = '0;
    end else if (sum_s > $signed({3'b000, ONE})) begin
      x_new = ONE;
    end else begin
      x_new = GW'(sum_s);
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    alpha_d = alpha_q;
    beta_d  = beta_q;
    x_d     = x_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    busy_d  = busy_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (gi.start) begin
          alpha_d[0] = gi.alpha_n;
          alpha_d[1] = gi.alpha_m;
          alpha_d[2] = gi.alpha_h;
          beta_d[0]  = gi.beta_n;
          beta_d[1]  = gi.beta_m;
          beta_d[2]  = gi.beta_h;
          g_d        = 2'd0;
          busy_d     = 1'b1;
          state_d    = MUL_A;
        end
      end
      MUL_A: begin
        p1_d    = prod_frac;
        state_d = MUL_B;
      end
      MUL_B: begin
        p2_d    = prod_frac;
        state_d = UPD;
      end
      UPD: begin
        case (g_q)
          2'd1:    x_d[1] = x_new;
          2'd2:    x_d[2] = x_new;
          default: x_d[0] = x_new;
        endcase
        if (g_q == 2'd2) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = IDLE;
        end else begin
          g_d     = g_q + 2'd1;
          state_d = MUL_A;
        end
      end
      default: state_d = IDLE;
    endcase

    // Clear overrides everything, including a same-cycle start
    if (gi.clear) begin
      alpha_d = alpha_q;
      beta_d  = beta_q;
      x_d[0]  = N0;
      x_d[1]  = M0;
      x_d[2]  = H0;
      g_d     = 2'd0;
      busy_d  = 1'b0;
      valid_d = 1'b0;
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      g_q     <= 2'd0;
      for (int i = 0; i < 3; i++) begin
        alpha_q[i] <= '0;
        beta_q[i]  <= '0;
      end
      x_q[0]  <= N0;
      x_q[1]  <= M0;
      x_q[2]  <= H0;
      p1_q    <= '0;
      p2_q    <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      alpha_q <= alpha_d;
      beta_q  <= beta_d;
      x_q     <= x_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign gi.n     = x_q[0];
  assign gi.m     = x_q[1];
  assign gi.h     = x_q[2];
  assign gi.busy  = busy_q;
  assign gi.valid = valid_q;

endmodule

// File: tb/tb_hh_gate_integrator.sv
// Directed self-checking bench for hh_gate_integrator: reset, equilibrium, growth,
// clamping, busy/clear rules and asynchronous reset mid-step.
module tb_hh_gate_integrator;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  hh_gate_if gif ();

  hh_gate_integrator dut (
    .clk   (clk),
    .rst_n (rst_n),
    .gi    (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rates(input logic [15:0] an, input logic [15:0] am, input logic [15:0] ah,
                           input logic [15:0] bn, input logic [15:0] bm, input logic [15:0] bh);
    gif.alpha_n = an;
    gif.alpha_m = am;
    gif.alpha_h = ah;
    gif.beta_n  = bn;
    gif.beta_m  = bm;
    gif.beta_h  = bh;
  endtask

  task automatic check_gates(input string tag, input int en, input int em, input int eh);
    check_eq({tag, ".n"}, 32'(gif.n), 32'(en));
    check_eq({tag, ".m"}, 32'(gif.m), 32'(em));
    check_eq({tag, ".h"}, 32'(gif.h), 32'(eh));
  endtask

  // One full step; checks busy after the start edge and valid latency/width
  task automatic do_step(input string tag);
    int lat;
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    check_eq({tag, ".busy"}, 32'(gif.busy), 32'd1);
    lat = 0;
    while (!gif.valid && lat < 30) begin
      tick();
      lat++;
    end
    check_eq({tag, ".lat"}, 32'(lat), 32'd9);
    check_eq({tag, ".busy_done"}, 32'(gif.busy), 32'd0);
    tick();
    check_eq({tag, ".valid_pulse"}, 32'(gif.valid), 32'd0);
  endtask

  task automatic count_valids(input int cycles, output int cnt);
    cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (gif.valid) cnt++;
    end
  endtask

  initial begin
    int vcnt;
    checks    = 0;
    errors    = 0;
    gif.start = 1'b1;
    gif.clear = 1'b0;
    set_rates(16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    rst_n = 1'b0;

    // Reset with start held high
    repeat (3) tick();
    check_gates("reset", 41, 7, 76);
    check_eq("reset.busy", 32'(gif.busy), 32'd0);
    check_eq("reset.valid", 32'(gif.valid), 32'd0);
    gif.start = 1'b0;
    #2 rst_n = 1'b1;
    repeat (2) tick();
    check_eq("post_reset.busy", 32'(gif.busy), 32'd0);
    check_gates("post_reset", 41, 7, 76);

    // Equilibrium: p1 = p2 = 27 for n
    set_rates(16'd41, 16'd0, 16'd0, 16'd87, 16'd0, 16'd0);
    do_step("equil");
    check_gates("equil", 41, 7, 76);

    // Growth: n 41 -> 46 -> 51
    set_rates(16'd128, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    do_step("grow1");
    check_gates("grow1", 46, 7, 76);
    do_step("grow2");
    check_gates("grow2", 51, 7, 76);

    // Clamp low on m, clamp high on h
    set_rates(16'd0, 16'd0, 16'hFFFF, 16'd0, 16'hFFFF, 16'd0);
    do_step("clamp1");
    check_gates("clamp1", 51, 0, 128);
    do_step("clamp2");
    check_gates("clamp2", 51, 0, 128);

    // Clear from idle
    gif.clear = 1'b1;
    tick();
    gif.clear = 1'b0;
    check_gates("clear_idle", 41, 7, 76);

    // Start pulses while busy are dropped
    set_rates(16'd128, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0);
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    tick();
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    tick();
    tick();
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    count_valids(20, vcnt);
    check_eq("busy_start.valids", 32'(vcnt), 32'd1);
    check_gates("busy_start", 46, 7, 76);

    // Clear at +4 aborts the step
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    repeat (3) tick();
    check_eq("abort.n_mid", 32'(gif.n), 32'd51);
    gif.clear = 1'b1;
    tick();
    gif.clear = 1'b0;
    check_gates("abort", 41, 7, 76);
    check_eq("abort.busy", 32'(gif.busy), 32'd0);
    count_valids(12, vcnt);
    check_eq("abort.valids", 32'(vcnt), 32'd0);
    check_gates("abort_after", 41, 7, 76);

    // Clear and start together: clear wins
    gif.clear = 1'b1;
    gif.start = 1'b1;
    tick();
    gif.clear = 1'b0;
    gif.start = 1'b0;
    check_eq("clr_start.busy", 32'(gif.busy), 32'd0);
    count_valids(12, vcnt);
    check_eq("clr_start.valids", 32'(vcnt), 32'd0);
    check_gates("clr_start", 41, 7, 76);

    // Async reset while in MUL_B for gate m
    gif.start = 1'b1;
    tick();
    gif.start = 1'b0;
    repeat (3) tick();
    check_eq("areset.n_pre", 32'(gif.n), 32'd46);
    tick();
    #3 rst_n = 1'b0;
    #1;
    check_gates("areset", 41, 7, 76);
    check_eq("areset.busy", 32'(gif.busy), 32'd0);
    check_eq("areset.valid", 32'(gif.valid), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    count_valids(12, vcnt);
    check_eq("areset.valids", 32'(vcnt), 32'd0);
    do_step("recover");
    check_gates("recover", 46, 7, 76);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
